program_counter: RTL and testbench
==================================

// Module: program_counter
// PURPOSE
//  16-bit Hack program counter: register with load / increment / clear
//  control, feeding the instruction-memory address. It sits upstream of
//  the Register/ROM fetch path and is driven by the CPU jump logic.
//  Adds a run/halt FSM and a wrap flag. An optional return-address stack
//  is selectable at compile time.
// PARAMETERS
//  WIDTH        16  data/address width
//  RESET_VECTOR 0   value loaded into pc by rst_n and by clr
//  STACK_DEPTH  4   return-stack entries (PC_STACK_EN only; power of 2, >=2)
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  clr        in   1      synchronous clear to RESET_VECTOR
//  load       in   1      load pc from in
//  in         in   WIDTH  jump target
//  inc        in   1      advance pc by 1
//  halt       in   1      request halt
//  push       in   1      call: save pc+1, jump to in (PC_STACK_EN)
//  pop        in   1      return: jump to top of stack (PC_STACK_EN)
//  out        out  WIDTH  current pc, registered
//  running    out  1      1 while FSM is in RUN
//  wrapped    out  1      one-cycle pulse: inc took pc from all-ones to 0
//  stk_err    out  1      sticky: push when full or pop when empty
// BEHAVIOUR
//  - Reset (rst_n=0, async): out=RESET_VECTOR, state=BOOT, running=0,
//    wrapped=0, stk_err=0, stack empty (sp=0).
//  - All updates occur on rising clk. out changes one cycle after the
//    controlling inputs are sampled. There is no combinational in->out path.
//  - FSM states:
//    - BOOT: one cycle after rst_n deasserts, then always goes to RUN.
//      Controls are ignored in BOOT.
//    - RUN: priority is clr > push > pop > load > inc > hold.
//      - halt=1 -> HALTED. The same-cycle control is still applied.
//    - HALTED: inc is ignored. clr, load, push and pop still apply.
//      - Any of clr/load/push/pop returns the FSM to RUN.
//      - halt has no further effect while already halted.
//  - running = (state==RUN), registered.
//  - Arithmetic is modulo 2^WIDTH.
//    - inc at all-ones gives 0 and sets wrapped=1 for exactly one cycle.
//    - load of 0 does not set wrapped.
//  - clr sets out=RESET_VECTOR, empties the stack (sp=0) and clears stk_err.
//  - Simultaneous load+inc: load wins, so out=in (not in+1).
//  - Deasserting rst_n mid-operation re-enters BOOT; stack contents are
//    discarded.
// CONFIGURATION
//  PC_STACK_EN defined:
//   - push: stack[sp]=out+1, sp++, out=in.
//   - pop: out=stack[sp-1], sp--.
//   - push when sp==STACK_DEPTH: out=in, stack unchanged, stk_err=1.
//   - pop when sp==0: out held, stk_err=1.
//   - push+pop together: push wins.
//  PC_STACK_EN undefined:
//   - push and pop are ignored (they are not treated as load).
//   - No stack storage is built; stk_err is tied to 0.
// TESTING
//  1. Reset, then 1 BOOT cycle, then inc for 3 cycles
//     -> out=0,0,1,2,3; running=1 from the 2nd cycle.
//  2. load=1, in=16'h8285 (-32123), then inc
//     -> out=16'h8285, then 16'h8286; load+inc together gives out=in.
//  3. load 16'hFFFF, then inc
//     -> out=0 with wrapped=1 for one cycle only; next inc gives out=1, wrapped=0.
//  4. halt in RUN with inc held high
//     -> out frozen, running=0; load 16'd12345 -> out=12345, running=1.
//  5. [PC_STACK_EN] at out=10, push in=100, then pop
//     -> out=100, then 11.
//     STACK_DEPTH+1 pushes -> stk_err=1; clr -> stk_err=0, out=0.
//  6. Assert rst_n low asynchronously mid-run with out=500
//     -> out=0 immediately without a clk edge, then BOOT/RUN sequence as in 1.

Source files
------------

// File: rtl/program_counter.sv
// Hack 16-bit program counter with run/halt FSM and wrap flag.
// Optional return-address stack is built when PC_STACK_EN is defined.
module program_counter #(
  parameter int WIDTH        = 16,
  parameter int RESET_VECTOR = 0,
  parameter int STACK_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  input  logic             inc,
  input  logic             halt,
  input  logic             push,
  input  logic             pop,
  output logic [WIDTH-1:0] out,
  output logic             running,
  output logic             wrapped,
  output logic             stk_err
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] RV   = WIDTH'(RESET_VECTOR);
  localparam logic [WIDTH-1:0] ONES = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             running_q, running_d;
  logic             wrapped_q, wrapped_d;

  logic             push_req, pop_req;
  logic             en_ctl;
  logic             do_clr, do_push, do_pop;
  logic             do_load, do_inc;

`ifdef PC_STACK_EN
  localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int SW = AW + 1;

  logic [WIDTH-1:0] stack_q [STACK_DEPTH];
  logic [WIDTH-1:0] stack_d [STACK_DEPTH];
  logic [SW-1:0]    sp_q, sp_d;
  logic             stk_err_q, stk_err_d;
  logic             full, empty;
  logic [AW-1:0]    top_idx;

  assign push_req = push;
  assign pop_req  = pop;
  assign full     = (sp_q == SW'(STACK_DEPTH));
  assign empty    = (sp_q == '0);
  assign top_idx  = sp_q[AW-1:0] - 1'b1;
  assign stk_err  = stk_err_q;
`else
  logic unused_stk;
  localparam int unused_depth = STACK_DEPTH;

  assign push_req   = 1'b0;
  assign pop_req    = 1'b0;
  assign unused_stk = ^{push, pop};
  assign stk_err    = 1'b0;
`endif

  assign out     = out_q;
  assign running = running_q;
  assign wrapped = wrapped_q;

  // Resolve which single control acts this cycle
  always_comb begin
    en_ctl  = (state_q != BOOT);
    do_clr  = en_ctl && clr;
    do_push = en_ctl && !clr && push_req;
    do_pop  = en_ctl && !clr && !push_req && pop_req;
    do_load = en_ctl && !clr && !push_req
              && !pop_req && load;
    do_inc  = (state_q == RUN) && !clr
              && !push_req && !pop_req
              && !load && inc;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (halt) begin
          state_d = HALTED;
        end
      end
      HALTED: begin
        if (clr || load || push_req || pop_req) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // FSM output: running tracks the state being entered
  always_comb begin
    running_d = (state_d == RUN);
  end

  // PC datapath, wrap detect and stack next-state
  always_comb begin
    out_d     = out_q;
    wrapped_d = 1'b0;
`ifdef PC_STACK_EN
    sp_d      = sp_q;
    stk_err_d = stk_err_q;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      stack_d[i] = stack_q[i];
    end
`endif
    unique case (1'b1)
      do_clr: begin
        out_d = RV;
`ifdef PC_STACK_EN
        sp_d      = '0;
        stk_err_d = 1'b0;
`endif
      end
`ifdef PC_STACK_EN
      do_push: begin
        out_d = in;
        if (full) begin
          stk_err_d = 1'b1;
        end else begin
          stack_d[sp_q[AW-1:0]] = out_q + 1'b1;
          sp_d = sp_q + 1'b1;
        end
      end
      do_pop: begin
        if (empty) begin
          stk_err_d = 1'b1;
        end else begin
          out_d = stack_q[top_idx];
          sp_d  = sp_q - 1'b1;
        end
      end
`endif
      do_load: begin
        out_d = in;
      end
      do_inc: begin
        out_d     = out_q + 1'b1;
        wrapped_d = (out_q == ONES);
      end
      default: begin
      end
    endcase
  end

  // PC and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= RV;
      running_q <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      out_q     <= out_d;
      running_q <= running_d;
      wrapped_q <= wrapped_d;
    end
  end

`ifdef PC_STACK_EN
  // Return stack, pointer and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q      <= '0;
      stk_err_q <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      sp_q      <= sp_d;
      stk_err_q <= stk_err_d;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_q[i] <= stack_d[i];
      end
    end
  end
`endif

endmodule

// File: tb/tb_program_counter.sv
// Directed bench for program_counter.
// Stack steps run only when PC_STACK_EN is defined.
module tb_program_counter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr, load, inc, halt;
  logic        push, pop;
  logic [15:0] pc_in;
  logic [15:0] pc_out;
  logic        running, wrapped, stk_err;

  int vectors    = 0;
  int miscompares = 0;

  program_counter #(
    .WIDTH(16),
    .RESET_VECTOR(0),
    .STACK_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clr(clr),
    .load(load),
    .in(pc_in),
    .inc(inc),
    .halt(halt),
    .push(push),
    .pop(pop),
    .out(pc_out),
    .running(running),
    .wrapped(wrapped),
    .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pc(input string tag,
                        input logic [15:0] e_out,
                        input logic e_run,
                        input logic e_wrap);
    chk({tag, ".out"}, {16'd0, pc_out}, {16'd0, e_out});
    chk({tag, ".running"}, {31'd0, running}, {31'd0, e_run});
    chk({tag, ".wrapped"}, {31'd0, wrapped}, {31'd0, e_wrap});
  endtask

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    load  = 1'b0;
    inc   = 1'b0;
    halt  = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    pc_in = 16'd0;
    #3;
    chk_pc("rst", 16'd0, 1'b0, 1'b0);
    chk("rst.stk_err", {31'd0, stk_err}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    inc   = 1'b1;

    // 1: BOOT ignores inc, then count
    step(); chk_pc("boot", 16'd0, 1'b1, 1'b0);
    step(); chk_pc("inc1", 16'd1, 1'b1, 1'b0);
    step(); chk_pc("inc2", 16'd2, 1'b1, 1'b0);
    step(); chk_pc("inc3", 16'd3, 1'b1, 1'b0);

    // 2: load with inc, load wins
    load = 1'b1; pc_in = 16'h8285;
    step(); chk_pc("ld_inc", 16'h8285, 1'b1, 1'b0);
    load = 1'b0;
    step(); chk_pc("ld_next", 16'h8286, 1'b1, 1'b0);

    // 3: wrap pulse
    inc = 1'b0; load = 1'b1; pc_in = 16'hFFFF;
    step(); chk_pc("ld_ffff", 16'hFFFF, 1'b1, 1'b0);
    load = 1'b0; inc = 1'b1;
    step(); chk_pc("wrap", 16'h0000, 1'b1, 1'b1);
    step(); chk_pc("wrap_end", 16'h0001, 1'b1, 1'b0);
    inc = 1'b0; load = 1'b1; pc_in = 16'h0000;
    step(); chk_pc("ld_zero", 16'h0000, 1'b1, 1'b0);

    // 4: halt, inc ignored, load resumes
    load = 1'b0; inc = 1'b1; halt = 1'b1;
    step(); chk_pc("halt", 16'd1, 1'b0, 1'b0);
    halt = 1'b0;
    step(); chk_pc("halt_hold", 16'd1, 1'b0, 1'b0);
    halt = 1'b1;
    step(); chk_pc("halt_again", 16'd1, 1'b0, 1'b0);
    halt = 1'b0; load = 1'b1; pc_in = 16'd12345;
    step(); chk_pc("resume", 16'd12345, 1'b1, 1'b0);
    load = 1'b0;
    step(); chk_pc("resume_inc", 16'd12346, 1'b1, 1'b0);

    // clr beats load
    inc = 1'b0; clr = 1'b1; load = 1'b1; pc_in = 16'h1234;
    step(); chk_pc("clr", 16'd0, 1'b1, 1'b0);
    clr = 1'b0; load = 1'b0;

`ifdef PC_STACK_EN
    // 5: call/return and stack errors
    load = 1'b1; pc_in = 16'd10;
    step(); chk_pc("ld10", 16'd10, 1'b1, 1'b0);
    load = 1'b0; push = 1'b1; pc_in = 16'd100;
    step(); chk_pc("push", 16'd100, 1'b1, 1'b0);
    push = 1'b0; pop = 1'b1;
    step(); chk_pc("pop", 16'd11, 1'b1, 1'b0);
    chk("pop.stk_err", {31'd0, stk_err}, 32'd0);
    pop = 1'b0; push = 1'b1; pc_in = 16'd200;
    for (int i = 0; i < 4; i++) begin
      step();
    end
    chk("fill.stk_err", {31'd0, stk_err}, 32'd0);
    step();
    chk_pc("ovf", 16'd200, 1'b1, 1'b0);
    chk("ovf.stk_err", {31'd0, stk_err}, 32'd1);
    push = 1'b0; clr = 1'b1;
    step(); chk_pc("sclr", 16'd0, 1'b1, 1'b0);
    chk("sclr.stk_err", {31'd0, stk_err}, 32'd0);
    clr = 1'b0; pop = 1'b1;
    step(); chk_pc("udf", 16'd0, 1'b1, 1'b0);
    chk("udf.stk_err", {31'd0, stk_err}, 32'd1);
    pop = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
`else
    // push/pop ignored without the stack
    push = 1'b1; pop = 1'b1; pc_in = 16'd100;
    step(); chk_pc("nostk", 16'd0, 1'b1, 1'b0);
    chk("nostk.stk_err", {31'd0, stk_err}, 32'd0);
    push = 1'b0; pop = 1'b0;
`endif

    // 6: async reset mid-run
    load = 1'b1; pc_in = 16'd500;
    step(); chk_pc("ld500", 16'd500, 1'b1, 1'b0);
    load = 1'b0; inc = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_pc("async_rst", 16'd0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    step(); chk_pc("reboot", 16'd0, 1'b1, 1'b0);
    step(); chk_pc("rinc1", 16'd1, 1'b1, 1'b0);
    step(); chk_pc("rinc2", 16'd2, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
